// File: rtl/bram_burst_responder.sv
// Block-fill responder: streams one aligned cache block out of a single-port
// synchronous BRAM (one-cycle read latency), flagging the final word with mem_last.
module bram_burst_responder #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 16,
   parameter int BLOCK_OFFSET_WIDTH = 5,
   parameter int WAIT_CYCLES        = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_enable,
   output logic [DATA_WIDTH-1:0] mem_read,
   output logic                  mem_read_valid,
   output logic                  mem_last,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_en,
   input  logic [DATA_WIDTH-1:0] bram_dout
);

   localparam logic [BLOCK_OFFSET_WIDTH-1:0] OFF_MAX   = '1;
   localparam logic [7:0]                    WAIT_LOAD = 8'(WAIT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0]         OFF_MASK  = ADDR_WIDTH'((1 << BLOCK_OFFSET_WIDTH) - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_HOLD} state_t;

   state_t                        state, state_next;
   logic [ADDR_WIDTH-1:0]         base;
   logic [BLOCK_OFFSET_WIDTH-1:0] offset;
   logic [7:0]                    wait_cnt;
   logic                          rd_flag, last_flag;
   logic                          accept, issue_fire;

   // Any state except IDLE treats a dropped mem_enable as an abort back to IDLE.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue_fire = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_enable) begin
               accept     = 1'b1;
               state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ISSUE;
            end
         end
         S_WAIT: begin
            if (!mem_enable)            state_next = S_IDLE;
            else if (wait_cnt == 8'd1)  state_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (!mem_enable) begin
               state_next = S_IDLE;
            end else begin
               issue_fire = 1'b1;
               if (offset == OFF_MAX) state_next = S_DRAIN;
            end
         end
         S_DRAIN: state_next = mem_enable ? S_HOLD : S_IDLE;
         S_HOLD:  if (!mem_enable) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // The offset saturates at the last word so a burst can never wrap into a second pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         base      <= '0;
         offset    <= '0;
         wait_cnt  <= '0;
         rd_flag   <= 1'b0;
         last_flag <= 1'b0;
      end else begin
         state     <= state_next;
         rd_flag   <= issue_fire;
         last_flag <= issue_fire && (offset == OFF_MAX);
         if (accept) begin
            base     <= mem_addr & ~OFF_MASK;
            offset   <= '0;
            wait_cnt <= WAIT_LOAD;
         end else begin
            if (state == S_WAIT) wait_cnt <= wait_cnt - 8'd1;
            if (issue_fire && (offset != OFF_MAX)) offset <= offset + 1'b1;
         end
      end
   end

   assign bram_en        = issue_fire;
   assign bram_addr      = issue_fire ? (base | {{(ADDR_WIDTH-BLOCK_OFFSET_WIDTH){1'b0}}, offset}) : '0;
   // Gating with mem_enable suppresses the in-flight word in the very cycle of an abort.
   assign mem_read_valid = rd_flag & mem_enable;
   assign mem_last       = last_flag & mem_enable;
   assign mem_read       = mem_read_valid ? bram_dout : '0;

endmodule

// File: tb/tb_bram_burst_responder.sv
// Scoreboard bench for bram_burst_responder: one instance with no wait cycles and one
// with three, each fed by its own behavioural BRAM and checked by a common monitor.
module tb_bram_burst_responder;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int BS = 32;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        last;
   } rd_t;

   typedef struct {
      int          cyc;
      logic [15:0] a;
   } is_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    [2];
   logic [AW-1:0] addr  [2];
   logic [DW-1:0] rd    [2];
   logic          valid [2];
   logic          last  [2];
   logic [AW-1:0] baddr [2];
   logic          ben   [2];
   logic [DW-1:0] dout  [2];

   rd_t rq0[$];
   rd_t rq1[$];
   is_t iq0[$];
   is_t iq1[$];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   bit mon_on = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bram_burst_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(5), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_addr(addr[0]), .mem_enable(en[0]),
      .mem_read(rd[0]), .mem_read_valid(valid[0]), .mem_last(last[0]),
      .bram_addr(baddr[0]), .bram_en(ben[0]), .bram_dout(dout[0])
   );

   bram_burst_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(5), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mem_addr(addr[1]), .mem_enable(en[1]),
      .mem_read(rd[1]), .mem_read_valid(valid[1]), .mem_last(last[1]),
      .bram_addr(baddr[1]), .bram_en(ben[1]), .bram_dout(dout[1])
   );

   function automatic logic [31:0] bramWord(input logic [15:0] a);
      return {16'h0000, a} * 32'd3;
   endfunction

   function automatic int waitOf(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   function automatic int clampBlock(input int v);
      if (v < 0) return 0;
      if (v > BS) return BS;
      return v;
   endfunction

   // Behavioural single-port BRAM: one-cycle read latency.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (ben[i]) dout[i] <= bramWord(baddr[i]);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   // Expected words and BRAM issues for a burst accepted in cycle t0.
   task automatic pushExpect(input int i, input logic [15:0] base, input int t0, input int nw, input int ni);
      rd_t r;
      is_t s;
      int  w;
      w = waitOf(i);
      for (int n = 0; n < nw; n++) begin
         r.cyc  = t0 + 2 + w + n;
         r.data = bramWord(base + 16'(n));
         r.last = (n == BS - 1);
         if (i == 0) rq0.push_back(r); else rq1.push_back(r);
      end
      for (int n = 0; n < ni; n++) begin
         s.cyc = t0 + 1 + w + n;
         s.a   = base + 16'(n);
         if (i == 0) iq0.push_back(s); else iq1.push_back(s);
      end
   endtask

   // abort_k < 0: full burst, enable dropped extra_hold cycles after the one following mem_last.
   // abort_k >= 1: enable dropped in cycle abort_k of the burst.
   task automatic applyStimulus(input int i, input logic [15:0] a, input int abort_k, input int extra_hold);
      int          t0, w, nw, ni, d;
      logic [15:0] base;
      t0   = cyc;
      w    = waitOf(i);
      base = a & 16'hFFE0;
      en[i]   = 1'b1;
      addr[i] = a;
      if (abort_k < 0) begin
         nw = BS;
         ni = BS;
         d  = t0 + 2 + w + BS + extra_hold;
      end else begin
         nw = clampBlock(abort_k - 2 - w);
         ni = clampBlock(abort_k - 1 - w);
         d  = t0 + abort_k;
      end
      pushExpect(i, base, t0, nw, ni);
      while (cyc < d) begin
         nextCycle();
         if (cyc < d) addr[i] = 16'($urandom);
      end
      en[i] = 1'b0;
      if (i == 0) begin
         checkOutput("words_left_0", 32'(rq0.size()), 32'd0);
         checkOutput("issues_left_0", 32'(iq0.size()), 32'd0);
      end else begin
         checkOutput("words_left_1", 32'(rq1.size()), 32'd0);
         checkOutput("issues_left_1", 32'(iq1.size()), 32'd0);
      end
   endtask

   task automatic monitorCycle(input int i);
      rd_t r;
      is_t s;
      bit  have;
      have = 1'b0;
      if (valid[i]) begin
         if (i == 0 && rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end
         if (i == 1 && rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end
         checkOutput("valid_expected", 32'(have), 32'd1);
         if (have) begin
            checkOutput("valid_cycle", 32'(cyc), 32'(r.cyc));
            checkOutput("read_data", rd[i], r.data);
            checkOutput("last_flag", 32'(last[i]), 32'(r.last));
         end
      end else begin
         checkOutput("idle_read_zero", rd[i], 32'd0);
         checkOutput("idle_last_zero", 32'(last[i]), 32'd0);
      end
      have = 1'b0;
      if (ben[i]) begin
         if (i == 0 && iq0.size() > 0) begin s = iq0.pop_front(); have = 1'b1; end
         if (i == 1 && iq1.size() > 0) begin s = iq1.pop_front(); have = 1'b1; end
         checkOutput("bram_en_expected", 32'(have), 32'd1);
         if (have) begin
            checkOutput("issue_cycle", 32'(cyc), 32'(s.cyc));
            checkOutput("bram_addr", 32'(baddr[i]), 32'(s.a));
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         monitorCycle(0);
         monitorCycle(1);
      end
   end

   task automatic checkAllZero(input int i);
      checkOutput("rst_valid", 32'(valid[i]), 32'd0);
      checkOutput("rst_last", 32'(last[i]), 32'd0);
      checkOutput("rst_read", rd[i], 32'd0);
      checkOutput("rst_bram_en", 32'(ben[i]), 32'd0);
      checkOutput("rst_bram_addr", 32'(baddr[i]), 32'd0);
   endtask

   initial begin
      int          i, w, k, t0;
      logic [15:0] a;
      for (int j = 0; j < 2; j++) begin
         en[j]   = 1'b0;
         addr[j] = '0;
      end
      #3;
      checkAllZero(0);
      checkAllZero(1);
      nextCycle();
      nextCycle();
      rst_n  = 1'b1;
      mon_on = 1'b1;
      nextCycle();

      applyStimulus(0, 16'h0120, -1, 0);
      nextCycle();
      applyStimulus(0, 16'h0127, -1, 0);
      nextCycle();
      applyStimulus(1, 16'h0040, -1, 0);
      nextCycle();
      applyStimulus(0, 16'h0400, 10, 0);
      nextCycle();
      applyStimulus(0, 16'h0200, -1, 0);
      nextCycle();
      applyStimulus(0, 16'h0280, -1, 0);
      nextCycle();
      nextCycle();
      applyStimulus(0, 16'h0300, -1, 0);
      nextCycle();
      applyStimulus(1, 16'h0700, 1 + 3 + BS, 0);
      nextCycle();
      applyStimulus(1, 16'h0900, 2, 0);
      nextCycle();
      applyStimulus(0, 16'h0A00, -1, 3);
      nextCycle();

      for (int n = 0; n < 16; n++) begin
         i = int'($urandom_range(0, 1));
         w = waitOf(i);
         a = 16'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(1, 1 + w + BS));
            applyStimulus(i, a, k, 0);
         end else begin
            applyStimulus(i, a, -1, int'($urandom_range(0, 3)));
         end
         repeat (int'($urandom_range(1, 3))) nextCycle();
      end

      // Asynchronous reset in the middle of an issuing burst.
      t0 = cyc;
      en[0]   = 1'b1;
      addr[0] = 16'h0500;
      pushExpect(0, 16'h0500, t0, BS, BS);
      repeat (10) nextCycle();
      rst_n = 1'b0;
      en[0] = 1'b0;
      #1;
      checkAllZero(0);
      checkAllZero(1);
      rq0.delete();
      iq0.delete();
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      repeat (6) nextCycle();
      applyStimulus(0, 16'h0600, -1, 0);
      nextCycle();
      nextCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bram_burst_responder.md
Name: bram_burst_responder

Overview:
- Memory-side responder for the cache block-fill interface (mem_addr / mem_enable / mem_read / mem_read_valid / mem_last).
- Sits between one L1 cache miss port and a single-port synchronous BRAM with one-cycle read latency.
- On each request it streams one full block, word offsets 0..BLOCK_SIZE-1 in order, and flags the final word with mem_last.
- WAIT_CYCLES inserts an optional first-access delay so benches can model slower memory.

Parameters:
DATA_WIDTH, 32, word width
ADDR_WIDTH, 16, word address width (1 word per address)
BLOCK_OFFSET_WIDTH, 5, log2 of words per block; BLOCK_SIZE = 1<<BLOCK_OFFSET_WIDTH
WAIT_CYCLES, 0, idle cycles inserted between request acceptance and the first BRAM read (0..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
mem_addr  in  ADDR_WIDTH  block base address from the cache; low BLOCK_OFFSET_WIDTH bits are ignored
mem_enable  in  1  request; held high by the cache for the whole burst
mem_read  out  DATA_WIDTH  read word; equals bram_dout while mem_read_valid=1, else 0
mem_read_valid  out  1  one pulse per delivered word
mem_last  out  1  high together with mem_read_valid on the final word (offset BLOCK_SIZE-1) only
bram_addr  out  ADDR_WIDTH  BRAM read address
bram_en  out  1  BRAM read enable
bram_dout  in  DATA_WIDTH  BRAM data, valid the cycle after bram_en

Behaviour:
- Reset (async, any state): state=IDLE; counters=0; mem_read_valid=0, mem_last=0, mem_read=0, bram_en=0, bram_addr=0. Any in-flight burst is dropped and no stray valid follows reset release.
- States: IDLE, WAIT, ISSUE, DRAIN, HOLD.
- IDLE: if mem_enable=1 at a rising edge, latch base={mem_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], zeros} and clear the offset counter. Go to WAIT if WAIT_CYCLES>0 (wait counter loaded with WAIT_CYCLES), else go to ISSUE.
- WAIT: counter decrements once per cycle; go to ISSUE in the cycle after it reaches 1. No BRAM activity.
- ISSUE: bram_en=1, bram_addr=base|offset; offset increments each cycle. After issuing offset BLOCK_SIZE-1, go to DRAIN. Offset counter width is BLOCK_OFFSET_WIDTH and is never allowed to wrap into a second pass.
- Data path: a registered flag marks each issued read; mem_read_valid = flag & mem_enable, one cycle after the matching bram_en.
- DRAIN: last word returns with mem_read_valid=1 and mem_last=1; go to HOLD.
- HOLD: no outputs active; return to IDLE once mem_enable=0. This absorbs the cycle in which the cache still holds mem_enable high after mem_last, so no second burst is triggered.
- Timing: cycle 0 is the first cycle mem_enable is sampled high in IDLE. Word at offset n is valid in cycle 2+WAIT_CYCLES+n. mem_last is in cycle 1+WAIT_CYCLES+BLOCK_SIZE. Throughput is one word per cycle with no gaps.
- Abort: if mem_enable=0 in WAIT, ISSUE or DRAIN, stop issuing from that cycle and return to IDLE next edge. Valid outputs are gated that same cycle, so no partial data and no mem_last are emitted.
- mem_addr changes during a burst are ignored; base is latched once per burst.
- Back-to-back bursts: after HOLD->IDLE, a new request is accepted on the first edge where mem_enable is high, so the minimum gap is one idle-enable cycle.

Test Plan:
- WAIT_CYCLES=0, BRAM word[a]=a*3, mem_enable held from cycle 0 with mem_addr=16'h0120 -> valid cycles 2..33 carry 0x360,0x363,...,0x3BD; mem_last only in cycle 33; bram_addr runs 0x0120..0x013F.
- mem_addr=16'h0127 (unaligned) -> same 32 words starting at 0x0120, offset 0 first.
- WAIT_CYCLES=3, mem_addr=16'h0040 -> first valid in cycle 5, mem_last in cycle 36, no bram_en in cycles 1..3.
- Drop mem_enable in cycle 10 of a burst -> no mem_read_valid from cycle 10 onward, no mem_last, bram_en=0 from cycle 10. A new request at 16'h0200 then streams cleanly from offset 0.
- Cache-style handshake: mem_enable falls one cycle after mem_last, then rises again two cycles later at 16'h0300 -> exactly 32 valids per burst, no duplicate burst.
- Assert rst_n=0 mid-ISSUE -> all outputs 0 immediately (async). After release with mem_enable=0, remain IDLE with no valid pulses.
